// File: rtl/ex_result_arbiter.sv
// EX->MEM result arbiter: per-FU result FIFOs, round-robin grant, registered valid/ready output.
module ex_result_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              fu0_valid,
    output logic              fu0_ready,
    input  logic [DATA_W-1:0] fu0_result,
    input  logic [DATA_W-1:0] fu0_pc,
    input  logic              fu1_valid,
    output logic              fu1_ready,
    input  logic [DATA_W-1:0] fu1_result,
    input  logic [DATA_W-1:0] fu1_pc,
    input  logic              fu2_valid,
    output logic              fu2_ready,
    input  logic [DATA_W-1:0] fu2_result,
    input  logic [DATA_W-1:0] fu2_pc,
    input  logic              fu2_op_write,
    input  logic              fu2_op_read,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_tunnel,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_pc,
    output logic              out_op_write,
    output logic              out_op_read,
    output logic              busy
);
    localparam int unsigned NUM_FU = 3;
    // Entry layout {result, pc, op_write, op_read}; op bits are tied low for fu0/fu1.
    localparam int unsigned ENT_W  = 2 * DATA_W + 2;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(DEPTH + 1);

    logic [ENT_W-1:0]  mem_q  [NUM_FU][DEPTH];
    logic [ENT_W-1:0]  mem_d  [NUM_FU][DEPTH];
    logic [AW-1:0]     wptr_q [NUM_FU];
    logic [AW-1:0]     wptr_d [NUM_FU];
    logic [AW-1:0]     rptr_q [NUM_FU];
    logic [AW-1:0]     rptr_d [NUM_FU];
    logic [CW-1:0]     cnt_q  [NUM_FU];
    logic [CW-1:0]     cnt_d  [NUM_FU];
    logic [1:0]        rr_q, rr_d;

    logic              out_valid_q, out_valid_d;
    logic [2:0]        out_tunnel_q, out_tunnel_d;
    logic [ENT_W-1:0]  out_ent_q, out_ent_d;

    logic [ENT_W-1:0]  din [NUM_FU];
    logic [NUM_FU-1:0] in_valid, fu_ready, nonempty, push, pop;
    logic              slot_free, gnt_any;
    logic [1:0]        gnt_idx;
    logic [2:0]        cand_sum;
    logic [ENT_W-1:0]  gnt_ent;

    assign din[0]   = {fu0_result, fu0_pc, 2'b00};
    assign din[1]   = {fu1_result, fu1_pc, 2'b00};
    assign din[2]   = {fu2_result, fu2_pc, fu2_op_write, fu2_op_read};
    assign in_valid = {fu2_valid, fu1_valid, fu0_valid};

    // Per-FU acceptance depends on registered occupancy only (no path from out_ready).
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ready[i] = (cnt_q[i] < CW'(DEPTH)) && !rst;
            nonempty[i] = (cnt_q[i] != '0);
        end
    end

    assign fu0_ready = fu_ready[0];
    assign fu1_ready = fu_ready[1];
    assign fu2_ready = fu_ready[2];
    assign slot_free = !out_valid_q || out_ready;

    // Round-robin search starting at rr_q, wrapping mod 3.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = 2'd0;
        cand_sum = 3'd0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand_sum = {1'b0, rr_q} + 3'(k);
            if (cand_sum >= 3'd3) cand_sum = cand_sum - 3'd3;
            if (!gnt_any && nonempty[cand_sum[1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_sum[1:0];
            end
        end
        gnt_ent = mem_q[gnt_idx][rptr_q[gnt_idx]];
    end

    // Next-state for FIFOs, round-robin pointer and the output slot.
    always_comb begin
        mem_d        = mem_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        out_valid_d  = out_valid_q;
        out_tunnel_d = out_tunnel_q;
        out_ent_d    = out_ent_q;
        for (int i = 0; i < NUM_FU; i++) begin
            push[i] = in_valid[i] && fu_ready[i];
            pop[i]  = slot_free && gnt_any && (gnt_idx == 2'(i));
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = din[i];
                wptr_d[i]           = wptr_q[i] + AW'(1);
            end
            if (pop[i]) rptr_d[i] = rptr_q[i] + AW'(1);
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
        if (slot_free) begin
            out_valid_d = gnt_any;
            if (gnt_any) begin
                out_tunnel_d = 3'b001 << gnt_idx;
                out_ent_d    = gnt_ent;
                rr_d         = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            end
        end
        // Flush drops everything in flight but keeps round-robin fairness state.
        if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wptr_d[i] = '0;
                rptr_d[i] = '0;
                cnt_d[i]  = '0;
            end
            out_valid_d = 1'b0;
            rr_d        = rr_q;
        end
    end

    // State registers; storage array needs no reset since counts gate every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_q         <= 2'd0;
            out_valid_q  <= 1'b0;
            out_tunnel_q <= 3'b000;
            out_ent_q    <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            out_valid_q  <= out_valid_d;
            out_tunnel_q <= out_tunnel_d;
            out_ent_q    <= out_ent_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_tunnel   = out_tunnel_q;
    assign out_result   = out_ent_q[ENT_W-1 -: DATA_W];
    assign out_pc       = out_ent_q[DATA_W+1 -: DATA_W];
    assign out_op_write = out_ent_q[1];
    assign out_op_read  = out_ent_q[0];
    assign busy         = nonempty[0] || nonempty[1] || nonempty[2] || out_valid_q;

endmodule

// File: tb/tb_ex_result_arbiter.sv
// Scoreboard bench for ex_result_arbiter: directed pushes, expected outputs queued in order.
module tb_ex_result_arbiter;
    typedef struct packed {
        logic [31:0] res;
        logic [31:0] pc;
        logic        w;
        logic        r;
    } item_t;

    typedef struct packed {
        logic [2:0] tun;
        item_t      it;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        fu0_valid, fu0_ready, fu1_valid, fu1_ready, fu2_valid, fu2_ready;
    logic [31:0] fu0_result, fu0_pc, fu1_result, fu1_pc, fu2_result, fu2_pc;
    logic        fu2_op_write, fu2_op_read;
    logic        out_valid, out_ready, out_op_write, out_op_read, busy;
    logic [2:0]  out_tunnel;
    logic [31:0] out_result, out_pc;

    int checks = 0;
    int errors = 0;

    item_t pend0[$], pend1[$], pend2[$];
    exp_t  sb[$];

    ex_result_arbiter #(.DATA_W(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu0_valid(fu0_valid), .fu0_ready(fu0_ready),
        .fu0_result(fu0_result), .fu0_pc(fu0_pc),
        .fu1_valid(fu1_valid), .fu1_ready(fu1_ready),
        .fu1_result(fu1_result), .fu1_pc(fu1_pc),
        .fu2_valid(fu2_valid), .fu2_ready(fu2_ready),
        .fu2_result(fu2_result), .fu2_pc(fu2_pc),
        .fu2_op_write(fu2_op_write), .fu2_op_read(fu2_op_read),
        .out_valid(out_valid), .out_ready(out_ready), .out_tunnel(out_tunnel),
        .out_result(out_result), .out_pc(out_pc),
        .out_op_write(out_op_write), .out_op_read(out_op_read), .busy(busy)
    );

    always #5 clk = ~clk;

    // A store that is also a load is never legal from fu2.
    always @(posedge clk) begin
        if (fu2_valid) assert (!(fu2_op_write && fu2_op_read)) else $error("illegal fu2 op");
    end

    // Monitor: every transfer accepted by the EX/MEM register is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t got, e;
            got = {out_tunnel, out_result, out_pc, out_op_write, out_op_read};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, required none", got);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb_output: got %h, required %h", got, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic item_t mk(input logic [31:0] res, input logic [31:0] pc,
                                 input logic w, input logic r);
        item_t it;
        it.res = res;
        it.pc  = pc;
        it.w   = w;
        it.r   = r;
        return it;
    endfunction

    function automatic exp_t mke(input logic [2:0] tun, input item_t it);
        exp_t e;
        e.tun = tun;
        e.it  = it;
        return e;
    endfunction

    // Present the head of each pending queue to its FU port.
    task automatic drive();
        fu0_valid = (pend0.size() != 0);
        fu1_valid = (pend1.size() != 0);
        fu2_valid = (pend2.size() != 0);
        {fu0_result, fu0_pc} = fu0_valid ? {pend0[0].res, pend0[0].pc} : 64'h0;
        {fu1_result, fu1_pc} = fu1_valid ? {pend1[0].res, pend1[0].pc} : 64'h0;
        {fu2_result, fu2_pc, fu2_op_write, fu2_op_read} =
            fu2_valid ? {pend2[0].res, pend2[0].pc, pend2[0].w, pend2[0].r} : 66'h0;
    endtask

    // One clock: record handshakes before the edge, retire accepted items after it.
    task automatic step();
        bit f0, f1, f2;
        @(negedge clk);
        f0 = fu0_valid && fu0_ready;
        f1 = fu1_valid && fu1_ready;
        f2 = fu2_valid && fu2_ready;
        @(posedge clk);
        #1;
        if (f0) void'(pend0.pop_front());
        if (f1) void'(pend1.pop_front());
        if (f2) void'(pend2.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            step();
            n++;
        end
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d entries left, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with every FU requesting.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        fu0_valid = 1'b1; fu0_result = 32'h1; fu0_pc = 32'h2;
        fu1_valid = 1'b1; fu1_result = 32'h3; fu1_pc = 32'h4;
        fu2_valid = 1'b1; fu2_result = 32'h5; fu2_pc = 32'h6;
        fu2_op_write = 1'b0; fu2_op_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_outputs", {out_valid, out_tunnel, out_result, out_pc,
                                  out_op_write, out_op_read, busy}, '0);
            check("rst_ready", {fu2_ready, fu1_ready, fu0_ready}, 3'b000);
        end
        rst = 1'b0;
        drive();
        #1;
        check("post_rst_ready", {fu2_ready, fu1_ready, fu0_ready}, 3'b111);
        step();
        step();
        check("rst_nothing_accepted", {out_valid, busy}, 2'b00);

        // Single fu1 result, two-cycle latency.
        do_reset();
        out_ready = 1'b1;
        pend1.push_back(mk(32'h11, 32'h100, 1'b0, 1'b0));
        sb.push_back(mke(3'b010, mk(32'h11, 32'h100, 1'b0, 1'b0)));
        drive();
        step();
        check("single_cyc1_idle", out_valid, 1'b0);
        step();
        check("single_cyc2", {out_valid, out_tunnel, out_result, out_pc},
              {1'b1, 3'b010, 32'h11, 32'h100});
        step();
        check("single_cyc3", {out_valid, busy}, 2'b00);
        drain("single");

        // Round-robin with all units streaming.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pend0.push_back(mk(32'h3000 + k, 32'h4000 + k, 1'b0, 1'b0));
            pend1.push_back(mk(32'h3010 + k, 32'h4010 + k, 1'b0, 1'b0));
            pend2.push_back(mk(32'h3020 + k, 32'h4020 + k, 1'b0, (k == 1)));
        end
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mke(3'b001, mk(32'h3000 + k, 32'h4000 + k, 1'b0, 1'b0)));
            sb.push_back(mke(3'b010, mk(32'h3010 + k, 32'h4010 + k, 1'b0, 1'b0)));
            sb.push_back(mke(3'b100, mk(32'h3020 + k, 32'h4020 + k, 1'b0, (k == 1))));
        end
        drive();
        drain("round_robin");

        // Backpressure on fu0 with the output stalled.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pend0.push_back(mk(32'hA0 + k, 32'h500 + 4 * k, 1'b0, 1'b0));
            sb.push_back(mke(3'b001, mk(32'hA0 + k, 32'h500 + 4 * k, 1'b0, 1'b0)));
        end
        drive();
        step();
        check("bp_ready_cyc1", fu0_ready, 1'b1);
        step();
        check("bp_ready_cyc2", fu0_ready, 1'b1);
        step();
        check("bp_ready_cyc3", fu0_ready, 1'b0);
        check("bp_d_held", {fu0_valid, fu0_result}, {1'b1, 32'hA3});
        step();
        check("bp_out_stable", {out_valid, out_tunnel, out_result, busy},
              {1'b1, 3'b001, 32'hA0, 1'b1});
        out_ready = 1'b1;
        drain("backpressure");

        // Store tagging from fu2.
        do_reset();
        out_ready = 1'b1;
        pend2.push_back(mk(32'hDEAD, 32'h200, 1'b1, 1'b0));
        sb.push_back(mke(3'b100, mk(32'hDEAD, 32'h200, 1'b1, 1'b0)));
        drive();
        step();
        step();
        check("store_out", {out_valid, out_tunnel, out_op_write, out_op_read, out_result},
              {1'b1, 3'b100, 1'b1, 1'b0, 32'hDEAD});
        drain("store");

        // Flush with buffered fu0/fu2 entries; rr_ptr must survive (points at fu1).
        do_reset();
        out_ready = 1'b0;
        pend0.push_back(mk(32'hB0, 32'h600, 1'b0, 1'b0));
        pend0.push_back(mk(32'hB1, 32'h604, 1'b0, 1'b0));
        pend2.push_back(mk(32'hC0, 32'h700, 1'b0, 1'b1));
        drive();
        step();
        step();
        check("pre_flush", {out_valid, out_tunnel, out_result, busy},
              {1'b1, 3'b001, 32'hB0, 1'b1});
        flush = 1'b1;
        pend1.push_back(mk(32'hEE, 32'h800, 1'b0, 1'b0));
        drive();
        step();
        flush = 1'b0;
        check("post_flush", {out_valid, busy, fu2_ready, fu1_ready, fu0_ready}, 5'b00111);
        step();
        check("flush_fu1_dropped", {out_valid, busy}, 2'b00);
        out_ready = 1'b1;
        pend0.push_back(mk(32'hD0, 32'h900, 1'b0, 1'b0));
        pend1.push_back(mk(32'hD1, 32'h910, 1'b0, 1'b0));
        pend2.push_back(mk(32'hD2, 32'h920, 1'b1, 1'b0));
        sb.push_back(mke(3'b010, mk(32'hD1, 32'h910, 1'b0, 1'b0)));
        sb.push_back(mke(3'b100, mk(32'hD2, 32'h920, 1'b1, 1'b0)));
        sb.push_back(mke(3'b001, mk(32'hD0, 32'h900, 1'b0, 1'b0)));
        drive();
        drain("flush_rr");
        check("final_idle", {out_valid, busy}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
